// File: rtl/aes_key_byte_loader.sv
// Key/block loader for the key expansion controller: accepts a 128-bit key and
// data block, streams the key MSB byte first and holds the block steady.
module aes_key_byte_loader #(
    parameter int unsigned NUM_BYTES = 16,
    parameter int unsigned BYTE_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_BYTES*BYTE_W-1:0]   in_key,
    input  logic [NUM_BYTES*BYTE_W-1:0]   in_block,
    input  logic                          dn_stall,
    output logic [BYTE_W-1:0]             key_byte,
    output logic                          key_byte_valid,
    output logic                          first_byte,
    output logic [NUM_BYTES*BYTE_W-1:0]   block_out,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned KEY_W = NUM_BYTES * BYTE_W;
    localparam int unsigned CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [KEY_W-1:0]     r_shift;
    logic [KEY_W-1:0]     w_shift_nxt;
    logic [KEY_W-1:0]     r_block;
    logic                 w_accept;

    logic [BYTE_W-1:0]    r_key_byte;
    logic                 r_key_byte_valid;
    logic                 r_first_byte;
    logic                 r_busy;
    logic                 r_done;

    logic [BYTE_W-1:0]    w_key_byte_nxt;
    logic                 w_stream_nxt;
    logic                 w_first_nxt;
    logic                 w_done_nxt;

    // Next-state, counter and shift-register update; outputs are precomputed
    // from the next-state values so they can be registered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_accept    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_shift_nxt = in_key;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!dn_stall) begin
                    w_shift_nxt = r_shift << BYTE_W;
                    if (r_cnt == CNT_W'(NUM_BYTES - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_stream_nxt   = (w_state_nxt == S_STREAM);
        w_key_byte_nxt = w_stream_nxt ? w_shift_nxt[KEY_W-1 -: BYTE_W] : '0;
        w_first_nxt    = w_stream_nxt && (w_cnt_nxt == '0);
        w_done_nxt     = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_shift          <= '0;
            r_block          <= '0;
            r_key_byte       <= '0;
            r_key_byte_valid <= 1'b0;
            r_first_byte     <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_shift          <= w_shift_nxt;
            if (w_accept) begin
                r_block <= in_block;
            end
            r_key_byte       <= w_key_byte_nxt;
            r_key_byte_valid <= w_stream_nxt;
            r_first_byte     <= w_first_nxt;
            r_busy           <= w_stream_nxt;
            r_done           <= w_done_nxt;
        end
    end

    // Ready is taken straight from the state so a new load can be offered the
    // same cycle the loader returns to idle.
    assign in_ready       = (r_state == S_IDLE);
    assign key_byte       = r_key_byte;
    assign key_byte_valid = r_key_byte_valid;
    assign first_byte     = r_first_byte;
    assign block_out      = r_block;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_aes_key_byte_loader.sv
// Bench for aes_key_byte_loader: table vectors, random loads with stalls, and
// hand sequences for back-to-back loads and mid-stream reset.
module tb_aes_key_byte_loader;

    localparam int unsigned NB = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] in_block;
    logic         dn_stall;
    logic [7:0]   key_byte;
    logic         key_byte_valid;
    logic         first_byte;
    logic [127:0] block_out;
    logic         busy;
    logic         done;

    int n_checks;
    int n_errors;

    aes_key_byte_loader #(.NUM_BYTES(16), .BYTE_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_key         (in_key),
        .in_block       (in_block),
        .dn_stall       (dn_stall),
        .key_byte       (key_byte),
        .key_byte_valid (key_byte_valid),
        .first_byte     (first_byte),
        .block_out      (block_out),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] blk;
        logic [63:0]  stalls;   // 4-bit stall count per byte index
        bit           noise;    // drive ignored in_valid/key during stream
        int           exp_lat;  // negedges from accept edge to done sample
    } vec_t;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BLK_A = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte i of a key, counting from the most significant byte.
    function automatic logic [7:0] model_byte(input logic [127:0] k, input int i);
        return 8'(k >> (8 * (15 - i)));
    endfunction

    // Follows one load from just after its accept edge to the return to idle.
    task automatic expect_stream(input logic [127:0] key, input logic [127:0] blk,
                                 input logic [63:0] stalls, input int exp_lat, input bit noise);
        int idx;
        int rem;
        int c;
        bit fin;
        idx = 0;
        rem = int'(stalls[3:0]);
        fin = 1'b0;
        c   = 0;
        while (!fin && c < 80) begin
            c++;
            @(negedge clk);
            if (key_byte_valid) begin
                if (idx >= NB) begin
                    check("byte_count_overrun", 128'(idx), 128'(NB - 1));
                    fin = 1'b1;
                end else begin
                    check("key_byte", 128'(key_byte), 128'(model_byte(key, idx)));
                    check("first_byte", 128'(first_byte), 128'(idx == 0));
                    check("block_out", block_out, blk);
                    check("busy", 128'(busy), 128'(1));
                    check("in_ready_stream", 128'(in_ready), 128'(0));
                    check("done_stream", 128'(done), 128'(0));
                    if (rem > 0) begin
                        dn_stall = 1'b1;
                        rem--;
                    end else begin
                        dn_stall = 1'b0;
                        idx++;
                        if (idx < NB) rem = int'(stalls[4*idx +: 4]);
                    end
                    if (noise) begin
                        in_valid = 1'($urandom_range(0, 1));
                        in_key   = '1;
                        in_block = '1;
                    end
                end
            end else begin
                check("done_pulse", 128'(done), 128'(1));
                check("bytes_consumed", 128'(idx), 128'(NB));
                check("done_latency", 128'(c), 128'(exp_lat));
                check("key_byte_zero", 128'(key_byte), 128'(0));
                check("busy_done", 128'(busy), 128'(0));
                check("in_ready_done", 128'(in_ready), 128'(0));
                check("block_out_done", block_out, blk);
                dn_stall = 1'($urandom_range(0, 1));
                in_valid = 1'b0;
                fin      = 1'b1;
            end
        end
        if (!fin) check("stream_timeout", 128'(c), 128'(exp_lat));
        @(negedge clk);
        check("in_ready_idle", 128'(in_ready), 128'(1));
        check("done_once", 128'(done), 128'(0));
        check("kbv_idle", 128'(key_byte_valid), 128'(0));
        check("block_out_hold", block_out, blk);
        dn_stall = 1'b0;
    endtask

    task automatic run_load(input vec_t v);
        @(negedge clk);
        check("ready_before_load", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_key   = v.key;
        in_block = v.blk;
        dn_stall = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        in_valid = v.noise;
        dn_stall = 1'b0;
        if (v.noise) begin
            in_key   = '1;
            in_block = '1;
        end
        expect_stream(v.key, v.blk, v.stalls, v.exp_lat, v.noise);
    endtask

    vec_t vecs[3];

    initial begin
        vec_t rv;
        int   acc1;
        int   acc2;
        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{key: KEY_A, blk: BLK_A, stalls: 64'h0, noise: 1'b0, exp_lat: 17};
        vecs[1] = '{key: KEY_A, blk: BLK_A, stalls: 64'h1000_0000_0003_0000, noise: 1'b0, exp_lat: 21};
        vecs[2] = '{key: KEY_A, blk: BLK_A, stalls: 64'h0, noise: 1'b1, exp_lat: 17};

        // Reset held with random inputs, then released into idle.
        rst = 1'b0; in_valid = 1'b0; in_key = '0; in_block = '0; dn_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            in_block = {$urandom, $urandom, $urandom, $urandom};
            dn_stall = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_in_ready", 128'(in_ready), 128'(1));
            check("rst_key_byte", 128'(key_byte), 128'(0));
            check("rst_kbv", 128'({first_byte, key_byte_valid, busy, done}), 128'(0));
            check("rst_block_out", block_out, 128'(0));
        end
        in_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_in_ready", 128'(in_ready), 128'(1));
            check("idle_outputs", 128'({key_byte, first_byte, key_byte_valid, busy, done}), 128'(0));
            check("idle_block_out", block_out, 128'(0));
        end

        // Table vectors: nominal, stalls on bytes 4 and 15, ignored input.
        for (int i = 0; i < 3; i++) run_load(vecs[i]);

        // Random loads; expected latency is 17 plus the total stall cycles.
        for (int i = 0; i < 6; i++) begin
            rv.key    = {$urandom, $urandom, $urandom, $urandom};
            rv.blk    = {$urandom, $urandom, $urandom, $urandom};
            rv.noise  = 1'($urandom_range(0, 1));
            rv.stalls = '0;
            rv.exp_lat = 17;
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rv.stalls[4*b +: 4] = 4'($urandom_range(1, 3));
                    rv.exp_lat += int'(rv.stalls[4*b +: 4]);
                end
            end
            run_load(rv);
        end

        // Back-to-back: in_valid held high, second accept 18 edges after first.
        @(negedge clk);
        in_valid = 1'b1; in_key = KEY_A; in_block = BLK_A;
        acc1 = -1; acc2 = -1;
        for (int n = 0; n < 60 && acc2 < 0; n++) begin
            if (n > 0) @(negedge clk);
            if (in_ready) begin
                if (acc1 < 0) begin
                    acc1 = n;
                    @(posedge clk);
                    #1;
                    in_key = KEY_B; in_block = ~BLK_A;
                end else begin
                    acc2 = n;
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                end
            end
        end
        if (acc1 < 0 || acc2 < 0) begin
            check("b2b_timeout", 128'(acc2), 128'(acc1 + 18));
        end else begin
            check("b2b_spacing", 128'(acc2 - acc1), 128'(18));
            expect_stream(KEY_B, ~BLK_A, 64'h0, 17, 1'b0);
        end

        // Mid-stream asynchronous reset while byte 7 is presented.
        @(negedge clk);
        in_valid = 1'b1; in_key = KEY_B; in_block = BLK_A;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) @(negedge clk);
        check("pre_reset_byte7", 128'(key_byte), 128'(model_byte(KEY_B, 7)));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_key_byte", 128'(key_byte), 128'(0));
        check("async_rst_flags", 128'({first_byte, key_byte_valid, busy, done}), 128'(0));
        check("async_rst_in_ready", 128'(in_ready), 128'(1));
        check("async_rst_block_out", block_out, 128'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_done_after_abort", 128'({busy, done}), 128'(0));
        end
        rst = 1'b1;
        @(negedge clk);
        check("post_abort_no_done", 128'(done), 128'(0));
        run_load(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_key_byte_loader.md
Name: aes_key_byte_loader

Overview:
- Upstream feeder for the key expansion controller.
- Accepts a 128-bit cipher key and a 128-bit data block through a valid/ready handshake.
- Streams the key MSB-byte-first, one byte per cycle, onto the controller's 8-bit key input, and holds the data block stable on the controller's 128-bit state input for the whole operation.
- Supports downstream stall and signals completion with a one-cycle pulse.

Parameters:
- NUM_BYTES, 16, number of key bytes streamed per load (128-bit key).
- BYTE_W, 8, width of each streamed byte.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- in_valid  input  1  upstream offers in_key/in_block.
- in_ready  output  1  loader can accept a new key/block this cycle.
- in_key  input  128  cipher key; bits [127:120] are byte 0.
- in_block  input  128  data block for the round datapath.
- dn_stall  input  1  downstream stall; freezes streaming while high.
- key_byte  output  8  current key byte to key expansion.
- key_byte_valid  output  1  key_byte is meaningful this cycle.
- first_byte  output  1  high while byte 0 is presented.
- block_out  output  128  registered copy of in_block.
- busy  output  1  high in STREAM.
- done  output  1  one-cycle pulse after the last byte is consumed.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, byte counter=0, key shift register=0.
  - block_out=0, key_byte=0, key_byte_valid=0, first_byte=0, busy=0, done=0, in_ready=1 (combinational from IDLE).
- FSM states IDLE, STREAM, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the loader captures in_key into the shift register, captures in_block into block_out, sets counter=0 and goes to STREAM.
  - block_out is written only on accept and otherwise holds its value across STREAM, DONE and IDLE.
- STREAM:
  - in_ready=0, busy=1, key_byte_valid=1.
  - key_byte = shift register [127:120] (registered).
  - first_byte = (counter==0).
  - On each edge with dn_stall=0: shift register shifts left by 8 (zero fill) and counter increments.
  - When counter==NUM_BYTES-1 and dn_stall=0, the next state is DONE and the counter wraps to 0.
  - With dn_stall=1 the counter, shift register and outputs all hold.
  - Stall may assert on any byte, including byte 0 and byte 15.
- DONE (exactly 1 cycle):
  - done=1, key_byte_valid=0, busy=0, in_ready=0. Then go to IDLE.
- Latency:
  - Byte 0 appears the cycle after the accept edge.
  - With no stall, byte k appears k+1 cycles after accept, done appears 17 cycles after accept, and in_ready returns 18 cycles after accept.
  - Each stall cycle adds one cycle.
- Boundary cases:
  - in_valid while not IDLE is ignored, and in_key/in_block changes have no effect.
  - in_valid held high continuously gives back-to-back loads: one every 18 cycles.
  - dn_stall in IDLE/DONE has no effect.
  - rst asserted mid-STREAM aborts immediately to reset values. No done is generated for the aborted load.
  - key_byte is 0 whenever key_byte_valid=0.

Test Plan:
- Reset check: hold rst=0 with random inputs -> all outputs 0 except in_ready=1. Release rst, idle 3 cycles -> no change.
- Nominal load: in_key=128'h2b7e151628aed2a6abf7158809cf4f3c, in_block=128'h3243f6a8885a308d313198a2e0370734, in_valid pulsed 1 cycle, dn_stall=0 -> key_byte sequence 2b,7e,15,16,28,ae,d2,a6,ab,f7,15,88,09,cf,4f,3c on 16 consecutive cycles with first_byte only on 2b. Then done=1 for one cycle, and block_out=3243...0734 throughout.
- Stall: same key, dn_stall=1 for 3 cycles while byte 4 (28) is presented and 1 cycle on byte 15 (3c) -> 28 held for 4 cycles, 3c held for 2 cycles, no bytes skipped or repeated, done at cycle 21 after accept.
- Ignored input: during STREAM drive in_valid=1 with in_key=all-ones -> stream and block_out are unchanged and in_ready stays 0 until IDLE.
- Back-to-back: in_valid held high with key A, then key B (128'h000102...0f) -> second accept occurs exactly 18 cycles after the first, and stream B is 00,01,...,0f.
- Mid-stream reset: assert rst=0 asynchronously (between edges) while byte 7 is presented -> outputs go to reset values immediately with no done pulse. A fresh load after reset streams from byte 0 correctly.
